// File: rtl/serial_bit_encoder_if.sv
// Handshake and status bundle between the controlling logic (master) and
// serial_bit_encoder (slave).
interface serial_bit_encoder_if #(
   parameter int DATA_WIDTH = 4
);
   logic                  start;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  serial_out;
   logic                  ready;
   logic                  busy;
   logic                  done;

   modport master (
      output start, data_in,
      input  serial_out, ready, busy, done
   );

   modport slave (
      input  start, data_in,
      output serial_out, ready, busy, done
   );
endinterface

// File: rtl/serial_bit_encoder.sv
// Captures a word on start and shifts it out bit by bit with a ready strobe per bit.
// Define SERIAL_ENCODER_PARITY_EN to append one even-parity bit period to every frame.
module serial_bit_encoder #(
   parameter int DATA_WIDTH = 4,
   parameter int BIT_PERIOD = 1,
   parameter bit MSB_FIRST  = 1'b1
) (
   input logic              clock,
   input logic              reset,
   serial_bit_encoder_if.slave bus
);

`ifdef SERIAL_ENCODER_PARITY_EN
   localparam int TOTAL_BITS = DATA_WIDTH + 1;
`else
   localparam int TOTAL_BITS = DATA_WIDTH;
`endif
   localparam int BIT_CNT_W = $clog2(TOTAL_BITS + 1);
   localparam logic [15:0]          PERIOD_RELOAD    = 16'(BIT_PERIOD - 1);
   localparam logic [BIT_CNT_W-1:0] BITS_AFTER_FIRST = BIT_CNT_W'(TOTAL_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t                state, stateNext;
   logic [DATA_WIDTH-1:0] shiftReg, shiftNext;
   logic [15:0]           periodCnt, periodNext;
   logic [BIT_CNT_W-1:0]  bitCnt, bitNext;
   logic                  serialQ, serialNext;
   logic                  readyQ, readyNext;
   logic                  busyQ, busyNext;
   logic                  doneQ, doneNext;
   logic [DATA_WIDTH-1:0] shiftedWord;
   logic                  firstBit;
   logic                  nextBit;
`ifdef SERIAL_ENCODER_PARITY_EN
   logic                  parityQ, parityNext;
`endif

   // State, datapath and all outputs are registered together so that no
   // output depends combinationally on an input.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shiftReg  <= '0;
         periodCnt <= '0;
         bitCnt    <= '0;
         serialQ   <= 1'b0;
         readyQ    <= 1'b0;
         busyQ     <= 1'b0;
         doneQ     <= 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
         parityQ   <= 1'b0;
`endif
      end else begin
         state     <= stateNext;
         shiftReg  <= shiftNext;
         periodCnt <= periodNext;
         bitCnt    <= bitNext;
         serialQ   <= serialNext;
         readyQ    <= readyNext;
         busyQ     <= busyNext;
         doneQ     <= doneNext;
`ifdef SERIAL_ENCODER_PARITY_EN
         parityQ   <= parityNext;
`endif
      end
   end

   // Next-state and next-output logic. bitCnt holds the number of bits still
   // to be sent after the one currently on serial_out; periodCnt counts the
   // remaining cycles of the current bit.
   always_comb begin
      stateNext   = state;
      shiftNext   = shiftReg;
      periodNext  = periodCnt;
      bitNext     = bitCnt;
      serialNext  = serialQ;
      readyNext   = 1'b0;
      busyNext    = busyQ;
      doneNext    = 1'b0;
`ifdef SERIAL_ENCODER_PARITY_EN
      parityNext  = parityQ;
`endif
      shiftedWord = MSB_FIRST ? (shiftReg << 1) : (shiftReg >> 1);
      firstBit    = MSB_FIRST ? bus.data_in[DATA_WIDTH-1] : bus.data_in[0];
      nextBit     = MSB_FIRST ? shiftedWord[DATA_WIDTH-1] : shiftedWord[0];

      case (state)
         IDLE: begin
            serialNext = 1'b0;
            busyNext   = 1'b0;
            if (bus.start) begin
               stateNext  = SHIFT;
               shiftNext  = bus.data_in;
               serialNext = firstBit;
               readyNext  = 1'b1;
               busyNext   = 1'b1;
               periodNext = PERIOD_RELOAD;
               bitNext    = BITS_AFTER_FIRST;
`ifdef SERIAL_ENCODER_PARITY_EN
               parityNext = ^bus.data_in;
`endif
            end
         end
         SHIFT: begin
            busyNext = 1'b1;
            if (periodCnt != 16'd0) begin
               periodNext = periodCnt - 16'd1;
            end else if (bitCnt != '0) begin
               shiftNext  = shiftedWord;
               serialNext = nextBit;
               readyNext  = 1'b1;
               periodNext = PERIOD_RELOAD;
               bitNext    = bitCnt - BIT_CNT_W'(1);
`ifdef SERIAL_ENCODER_PARITY_EN
               if (bitCnt == BIT_CNT_W'(1)) begin
                  serialNext = parityQ;
               end
`endif
            end else begin
               stateNext  = DONE;
               doneNext   = 1'b1;
               serialNext = 1'b0;
               shiftNext  = '0;
               periodNext = '0;
               bitNext    = '0;
            end
         end
         DONE: begin
            stateNext  = IDLE;
            busyNext   = 1'b0;
            serialNext = 1'b0;
         end
         default: begin
            stateNext  = IDLE;
            busyNext   = 1'b0;
            serialNext = 1'b0;
         end
      endcase
   end

   assign bus.serial_out = serialQ;
   assign bus.ready      = readyQ;
   assign bus.busy       = busyQ;
   assign bus.done       = doneQ;

endmodule

// File: tb/tb_serial_bit_encoder.sv
// Directed self-checking bench: encoder A (BIT_PERIOD=1, MSB first) and
// encoder B (BIT_PERIOD=3, LSB first). Honours SERIAL_ENCODER_PARITY_EN.
module tb_serial_bit_encoder;

`ifdef SERIAL_ENCODER_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   serial_bit_encoder_if #(.DATA_WIDTH(4)) busA ();
   serial_bit_encoder_if #(.DATA_WIDTH(4)) busB ();

   serial_bit_encoder #(.DATA_WIDTH(4), .BIT_PERIOD(1), .MSB_FIRST(1'b1)) dutA (
      .clock (clock),
      .reset (reset),
      .bus   (busA)
   );

   serial_bit_encoder #(.DATA_WIDTH(4), .BIT_PERIOD(3), .MSB_FIRST(1'b0)) dutB (
      .clock (clock),
      .reset (reset),
      .bus   (busB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input int which, input logic s, input logic [3:0] d);
      if (which == 0) begin
         busA.start   = s;
         busA.data_in = d;
      end else begin
         busB.start   = s;
         busB.data_in = d;
      end
   endtask

   // Packs {serial_out, ready, busy, done} of the selected encoder.
   function automatic logic [3:0] sampleOut(input int which);
      if (which == 0)
         return {busA.serial_out, busA.ready, busA.busy, busA.done};
      return {busB.serial_out, busB.ready, busB.busy, busB.done};
   endfunction

   // Caller has set start/data for the accept edge and sits at a negedge.
   // Walks the whole frame plus the following IDLE cycle. At cycle injAt the
   // bench raises start with injData; holdStart keeps start high throughout.
   task automatic checkFrame(input string tag, input int which, input logic [3:0] word,
                             input int bp, input bit msb, input int injAt,
                             input logic [3:0] injData, input bit holdStart);
      int          nBits;
      int          idx;
      logic        expBit;
      logic        expReady;
      logic [3:0]  obs;
      logic [3:0]  curData;
      nBits   = 4 + PAR_BITS;
      curData = word;
      for (int c = 1; c <= nBits * bp + 2; c++) begin
         @(negedge clock);
         obs = sampleOut(which);
         if (c <= nBits * bp) begin
            idx      = (c - 1) / bp;
            expReady = ((c - 1) % bp) == 0;
            if (idx >= 4)
               expBit = ^word;
            else if (msb)
               expBit = word[3 - idx];
            else
               expBit = word[idx];
            checkOutput($sformatf("%s c%0d serial", tag, c), 32'(obs[3]), 32'(expBit));
            checkOutput($sformatf("%s c%0d ready", tag, c), 32'(obs[2]), 32'(expReady));
            checkOutput($sformatf("%s c%0d busy/done", tag, c), 32'(obs[1:0]), 32'h2);
         end else if (c == nBits * bp + 1) begin
            checkOutput($sformatf("%s c%0d done", tag, c), 32'(obs), 32'h3);
         end else begin
            checkOutput($sformatf("%s c%0d idle", tag, c), 32'(obs), 32'h0);
         end
         if (c == 1 && !holdStart) applyStimulus(which, 1'b0, curData);
         if (c == injAt) begin
            curData = injData;
            applyStimulus(which, 1'b1, curData);
         end
         if (c == injAt + 1 && !holdStart) applyStimulus(which, 1'b0, curData);
      end
   endtask

   initial begin
      logic [3:0] obs;
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      applyStimulus(0, 1'b0, 4'h0);
      applyStimulus(1, 1'b0, 4'h0);
      repeat (3) @(negedge clock);
      checkOutput("reset A", 32'(sampleOut(0)), 32'h0);
      checkOutput("reset B", 32'(sampleOut(1)), 32'h0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("idle A", 32'(sampleOut(0)), 32'h0);

      $display("[TB] reset mid-frame");
      applyStimulus(0, 1'b1, 4'b1011);
      @(negedge clock);
      applyStimulus(0, 1'b0, 4'b1011);
      checkOutput("midrst bit0", 32'(sampleOut(0)), 32'hE);
      @(negedge clock);
      checkOutput("midrst bit1", 32'(sampleOut(0)), 32'h6);
      @(negedge clock);
      checkOutput("midrst bit2", 32'(sampleOut(0)), 32'hE);
      #1 reset = 1'b0;
      #1 checkOutput("midrst async clear", 32'(sampleOut(0)), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput($sformatf("midrst held %0d", i), 32'(sampleOut(0)), 32'h0);
      end
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         checkOutput($sformatf("midrst after %0d", i), 32'(sampleOut(0)), 32'h0);
      end

      $display("[TB] basic frames");
      applyStimulus(0, 1'b1, 4'b1010);
      checkFrame("A 1010", 0, 4'b1010, 1, 1'b1, 0, 4'h0, 1'b0);
      applyStimulus(1, 1'b1, 4'b0110);
      checkFrame("B 0110", 1, 4'b0110, 3, 1'b0, 0, 4'h0, 1'b0);
      applyStimulus(1, 1'b1, 4'b0000);
      checkFrame("B 0000", 1, 4'b0000, 3, 1'b0, 0, 4'h0, 1'b0);
      applyStimulus(0, 1'b1, 4'b1111);
      checkFrame("A 1111", 0, 4'b1111, 1, 1'b1, 0, 4'h0, 1'b0);
      applyStimulus(0, 1'b1, 4'b0111);
      checkFrame("A 0111", 0, 4'b0111, 1, 1'b1, 0, 4'h0, 1'b0);

      $display("[TB] start while busy");
      applyStimulus(0, 1'b1, 4'b0011);
      checkFrame("A ignore", 0, 4'b0011, 1, 1'b1, 2, 4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         checkOutput($sformatf("A ignore idle %0d", i), 32'(sampleOut(0)), 32'h0);
      end
      applyStimulus(1, 1'b1, 4'b1001);
      checkFrame("B ignore", 1, 4'b1001, 3, 1'b0, 5, 4'b0110, 1'b0);

      $display("[TB] start held high");
      applyStimulus(0, 1'b1, 4'b0001);
      checkFrame("A held 1st", 0, 4'b0001, 1, 1'b1, 1, 4'b1000, 1'b1);
      checkFrame("A held 2nd", 0, 4'b1000, 1, 1'b1, 0, 4'h0, 1'b0);
      @(negedge clock);
      obs = sampleOut(0);
      checkOutput("A held end idle", 32'(obs), 32'h0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
